// File: rtl/comb_check_pkg.sv
// Shared types and helpers for the combinational equivalence checker.
// Holds the sweep FSM state type and the settle-counter width function.
package comb_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // The counter only ever holds SETTLE-1 down to 0, so clog2(SETTLE) bits suffice.
    function automatic int settle_w(input int settle);
        settle_w = (settle <= 1) ? 1 : $clog2(settle);
    endfunction

endpackage

// File: rtl/comb_check_settle_timer.sv
// Load-and-count-down timer that times the HOLD phase of each vector.
// A load arms it for SETTLE cycles; expired_o is high on the last of them.
module comb_check_settle_timer
    import comb_check_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic expired_o
);

    localparam int W = settle_w(SETTLE);
    localparam logic [W-1:0] LOAD_VAL = (SETTLE > 0) ? W'(SETTLE - 1) : '0;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/comb_equiv_checker.sv
// Exhaustive-sweep stimulus and compare engine for N_IMPL parallel implementations.
// Reports pass/fail, a saturating-free mismatch count and the first failing vector.
//
// state | meaning
// IDLE  | waiting for start after reset
// HOLD  | vector applied, waiting out the settle time
// CHECK | one-cycle compare of all implementations against bit 0
// DONE  | sweep finished, verdict valid until next start
module comb_equiv_checker
    import comb_check_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int N_IMPL = 4,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   vec,
    input  logic [N_IMPL-1:0] dut_out,
    output logic              busy,
    output logic              sample,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_bad_vec,
    output logic [N_IMPL-1:0] first_bad_mask
);

    // With no settle time a freshly loaded vector is compared immediately.
    localparam state_e LOAD_ST = (SETTLE == 0) ? ST_CHECK : ST_HOLD;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [N_IN:0]     err_q, err_d;
    logic [N_IN-1:0]   fbv_q, fbv_d;
    logic [N_IMPL-1:0] fbm_q, fbm_d;

    logic              load_timer;
    logic              expired;
    logic [N_IMPL-1:0] mask;
    logic              mismatch;

    comb_check_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load_timer),
        .expired_o (expired)
    );

    assign mask = dut_out ^ {N_IMPL{dut_out[0]}};

    // Written as "equal to zero or else mismatch" so an unknown mask falls into the mismatch branch.
    always_comb begin
        mismatch = 1'b1;
        if (mask == '0) begin
            mismatch = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        err_d      = err_q;
        fbv_d      = fbv_q;
        fbm_d      = fbm_q;
        load_timer = 1'b0;

        case (state_q)
            ST_HOLD: begin
                if (expired) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + (N_IN + 1)'(1);
                    if (err_q == '0) begin
                        fbv_d = vec_q;
                        fbm_d = mask;
                    end
                end
                if (vec_q == '1) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d      = vec_q + N_IN'(1);
                    state_d    = LOAD_ST;
                    load_timer = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    state_d    = LOAD_ST;
                    vec_d      = '0;
                    err_d      = '0;
                    fbv_d      = '0;
                    fbm_d      = '0;
                    load_timer = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            fbv_q   <= '0;
            fbm_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            fbv_q   <= fbv_d;
            fbm_q   <= fbm_d;
        end
    end

    assign vec            = vec_q;
    assign busy           = (state_q == ST_HOLD) || (state_q == ST_CHECK);
    assign sample         = (state_q == ST_CHECK);
    assign done           = (state_q == ST_DONE);
    assign pass           = (state_q == ST_DONE) && (err_q == '0);
    assign err_count      = err_q;
    assign first_bad_vec  = fbv_q;
    assign first_bad_mask = fbm_q;

endmodule

// File: tb/tb_comb_equiv_checker.sv
// Bench for comb_equiv_checker: table-driven fault cases, randomized fault maps
// against a sweep-level reference model, and hand-written timing/reset sequences.
module tb_comb_equiv_checker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Default configuration: N_IN=4, N_IMPL=4, SETTLE=2
    logic       start_a;
    logic [3:0] vec_a;
    logic [3:0] dut_a;
    logic       busy_a, sample_a, done_a, pass_a;
    logic [4:0] err_a;
    logic [3:0] fbv_a;
    logic [3:0] fbm_a;

    // Small configuration: N_IN=3, N_IMPL=2, SETTLE=0
    logic       start_b;
    logic [2:0] vec_b;
    logic [1:0] dut_b;
    logic       busy_b, sample_b, done_b, pass_b;
    logic [3:0] err_b;
    logic [2:0] fbv_b;
    logic [1:0] fbm_b;

    comb_equiv_checker #(.N_IN(4), .N_IMPL(4), .SETTLE(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .vec(vec_a), .dut_out(dut_a),
        .busy(busy_a), .sample(sample_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_bad_vec(fbv_a), .first_bad_mask(fbm_a)
    );

    comb_equiv_checker #(.N_IN(3), .N_IMPL(2), .SETTLE(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .vec(vec_b), .dut_out(dut_b),
        .busy(busy_b), .sample(sample_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_bad_vec(fbv_b), .first_bad_mask(fbm_b)
    );

    // Implementations under test: the golden function with per-vector fault bits.
    logic [3:0] corrupt_a [16];
    logic [1:0] corrupt_b [8];
    bit         x_en;
    int         x_vec;

    function automatic logic [3:0] drive_a(input logic [3:0] v);
        logic       g;
        logic [3:0] d;
        g = (v[0] ^ (v[1] & v[2])) | v[3];
        d = {4{g}} ^ corrupt_a[v];
        if (x_en && (32'(v) == x_vec)) d[1] = 1'bx;
        return d;
    endfunction

    function automatic logic [1:0] drive_b(input logic [2:0] v);
        logic g;
        g = v[0] ^ (v[1] & v[2]);
        return {2{g}} ^ corrupt_b[v];
    endfunction

    always_comb dut_a = drive_a(vec_a);
    always_comb dut_b = drive_b(vec_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_faults();
        for (int v = 0; v < 16; v++) corrupt_a[v] = 4'b0;
        for (int v = 0; v < 8; v++)  corrupt_b[v] = 2'b0;
        x_en  = 1'b0;
        x_vec = -1;
    endtask

    // Reference: walk every vector and apply the compare rule to what is driven.
    task automatic model_a(output int e, output int fv, output logic [3:0] fm);
        logic [3:0] d;
        logic [3:0] m;
        e  = 0;
        fv = 0;
        fm = 4'b0;
        for (int v = 0; v < 16; v++) begin
            d = drive_a(4'(v));
            m = d ^ {4{d[0]}};
            if (!(m === 4'b0)) begin
                if (e == 0) begin
                    fv = v;
                    fm = m;
                end
                e++;
            end
        end
    endtask

    // Runs one sweep on the default instance, returns cycle-level observations.
    task automatic sweep_a(input bit noise, input bit timing);
        int cyc, samples, first_s, last_s, gap_bad, vec_bad;
        logic prev_sample;
        logic [3:0] prev_vec;
        logic busy1, vec1;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        cyc = 1; samples = 0; first_s = 0; last_s = 0; gap_bad = 0; vec_bad = 0;
        busy1 = busy_a;
        vec1  = (vec_a == 4'd0);
        prev_sample = 1'b0;
        prev_vec    = vec_a;
        while (!done_a && cyc < 200) begin
            if (vec_a != prev_vec && !prev_sample) vec_bad++;
            if (sample_a) begin
                if (samples == 0) first_s = cyc;
                else if (cyc - last_s != 3) gap_bad++;
                last_s = cyc;
                samples++;
            end
            prev_sample = sample_a;
            prev_vec    = vec_a;
            if (noise) start_a = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        start_a = 1'b0;
        chk("sweep_done_reached", 32'(done_a), 32'd1);
        chk("vec_only_after_check", 32'(vec_bad), 32'd0);
        if (timing) begin
            chk("busy_first_cycle", 32'(busy1), 32'd1);
            chk("vec_zero_first_cycle", 32'(vec1), 32'd1);
            chk("sample_count", 32'(samples), 32'd16);
            chk("first_sample_cycle", 32'(first_s), 32'd3);
            chk("sample_spacing", 32'(gap_bad), 32'd0);
            chk("done_cycle", 32'(cyc), 32'd49);
            chk("busy_low_in_done", 32'(busy_a), 32'd0);
            chk("vec_hold_in_done", 32'(vec_a), 32'd15);
        end
    endtask

    typedef struct {
        string name;
        int    fimpl;
        int    fvec;
        bit    xen;
        int    exp_err;
        int    exp_vec;
        int    exp_mask;
        bit    chk_mask;
        bit    exp_pass;
    } case_t;

    case_t tbl [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, fv;
        logic [3:0] fm;
        int cyc, samples, first_s, consec_bad;

        tbl[0] = '{"all_equal",      0, -2, 1'b0,  0,  0, 4'b0000, 1'b1, 1'b1};
        tbl[1] = '{"impl2_at_0101",  2,  5, 1'b0,  1,  5, 4'b0100, 1'b1, 1'b0};
        tbl[2] = '{"impl3_inverted", 3, -1, 1'b0, 16,  0, 4'b1000, 1'b1, 1'b0};
        tbl[3] = '{"impl1_x_at_1010",1, 10, 1'b1,  1, 10, 4'b0000, 1'b0, 1'b0};

        clear_faults();
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_vec",   32'(vec_a), 32'd0);
        chk("reset_flags", 32'({busy_a, sample_a, done_a, pass_a}), 32'd0);
        chk("reset_stats", 32'({err_a, fbv_a, fbm_a}), 32'd0);
        chk("reset_b",     32'({vec_b, busy_b, sample_b, done_b, pass_b, err_b, fbv_b, fbm_b}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            clear_faults();
            if (tbl[i].xen) begin
                x_en  = 1'b1;
                x_vec = tbl[i].fvec;
            end else if (tbl[i].fvec == -1) begin
                for (int v = 0; v < 16; v++) corrupt_a[v][tbl[i].fimpl] = 1'b1;
            end else if (tbl[i].fvec >= 0) begin
                corrupt_a[tbl[i].fvec][tbl[i].fimpl] = 1'b1;
            end
            sweep_a(1'b0, 1'b1);
            chk({tbl[i].name, "_err"},  32'(err_a), 32'(tbl[i].exp_err));
            chk({tbl[i].name, "_vec"},  32'(fbv_a), 32'(tbl[i].exp_vec));
            if (tbl[i].chk_mask) chk({tbl[i].name, "_mask"}, 32'(fbm_a), 32'(tbl[i].exp_mask));
            chk({tbl[i].name, "_pass"}, 32'(pass_a), 32'(tbl[i].exp_pass));
        end

        // Randomized fault maps, with start toggled while busy.
        for (int r = 0; r < 6; r++) begin
            clear_faults();
            for (int v = 0; v < 16; v++)
                if ($urandom_range(0, 3) == 0) corrupt_a[v] = 4'($urandom);
            model_a(e, fv, fm);
            sweep_a(1'b1, 1'b0);
            chk("rand_err",  32'(err_a), 32'(e));
            chk("rand_pass", 32'(pass_a), 32'(e == 0));
            if (e != 0) begin
                chk("rand_first_vec",  32'(fbv_a), 32'(fv));
                chk("rand_first_mask", 32'(fbm_a), 32'(fm));
            end
        end

        // Zero-settle instance with start held high: restart only from DONE.
        clear_faults();
        corrupt_b[3] = 2'b10;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk);
        cyc = 1; samples = 0; first_s = 0; consec_bad = 0;
        while (!done_b && cyc < 50) begin
            if (sample_b) begin
                if (samples == 0) first_s = cyc;
                samples++;
            end else consec_bad++;
            @(negedge clk);
            cyc++;
        end
        chk("b_sample_count", 32'(samples), 32'd8);
        chk("b_first_sample", 32'(first_s), 32'd1);
        chk("b_no_gaps",      32'(consec_bad), 32'd0);
        chk("b_done_cycle",   32'(cyc), 32'd9);
        chk("b_err",          32'(err_b), 32'd1);
        chk("b_first_vec",    32'(fbv_b), 32'd3);
        chk("b_first_mask",   32'(fbm_b), 32'd2);
        chk("b_pass",         32'(pass_b), 32'd0);
        corrupt_b[3] = 2'b00;
        @(negedge clk);
        chk("b_restart_busy",  32'({busy_b, done_b}), 32'b10);
        chk("b_restart_stats", 32'({vec_b, err_b, fbv_b, fbm_b}), 32'd0);
        cyc = 0;
        while (!done_b && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        start_b = 1'b0;
        chk("b_second_done", 32'(done_b), 32'd1);
        chk("b_second_pass", 32'({pass_b, err_b}), 32'b10000);

        // Reset mid-sweep at vector 7 with two errors already counted.
        clear_faults();
        corrupt_a[2] = 4'b0100;
        corrupt_a[5] = 4'b0100;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        cyc = 0;
        while (vec_a != 4'd7 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_reached_vec7", 32'(vec_a), 32'd7);
        chk("rst_err_before",   32'(err_a), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_flags", 32'({busy_a, sample_a, done_a, pass_a}), 32'd0);
        chk("rst_vec",   32'(vec_a), 32'd0);
        chk("rst_stats", 32'({err_a, fbv_a, fbm_a}), 32'd0);
        @(negedge clk);
        chk("rst_stays_idle", 32'({busy_a, done_a}), 32'd0);
        clear_faults();
        sweep_a(1'b0, 1'b1);
        chk("post_rst_pass", 32'({pass_a, err_a}), 32'b100000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
